// File: rtl/dot4_pkg.sv
// Shared constants and types for the sequential 4-term Q0.6 dot-product MAC.
package dot4_pkg;

  localparam int unsigned DW      = 6;
  localparam int unsigned FRAC    = 6;
  localparam int unsigned N_TERMS = 4;
  localparam int unsigned RW      = 9;
  localparam int unsigned FW      = 14;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  typedef logic [1:0] idx_t;

endpackage

// File: rtl/q06_mul_trunc.sv
// Combinational unsigned Q0.6 multiplier: full 12-bit product and the product
// truncated back to Q0.6 (right shift by FRAC, no rounding).
module q06_mul_trunc
  import dot4_pkg::*;
(
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] prod_full,
  output logic [DW-1:0]   prod_trunc
);

  assign prod_full  = (2*DW)'(a) * (2*DW)'(b);
  assign prod_trunc = prod_full[2*DW-1:FRAC];

endmodule

// File: rtl/dot4_mac_seq.sv
// Sequential dot4 MAC: captures eight Q0.6 operands on en_in, accumulates one
// product per cycle through a shared multiplier, and pulses en_out with results.
module dot4_mac_seq
  import dot4_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic [DW-1:0] num1,
  input  logic [DW-1:0] num2,
  input  logic [DW-1:0] num3,
  input  logic [DW-1:0] num4,
  input  logic [DW-1:0] num5,
  input  logic [DW-1:0] num6,
  input  logic [DW-1:0] num7,
  input  logic [DW-1:0] num8,
  output logic          busy,
  output logic          en_out,
  output logic [RW-1:0] result,
  output logic [FW-1:0] result_full
);

  state_t          r_state;
  state_t          w_next;
  idx_t            r_idx;
  logic [DW-1:0]   r_op [2*N_TERMS];
  logic [RW-1:0]   r_acc_t;
  logic [FW-1:0]   r_acc_f;
  logic [RW-1:0]   r_result;
  logic [FW-1:0]   r_result_full;

  logic [DW-1:0]   w_a;
  logic [DW-1:0]   w_b;
  logic [2*DW-1:0] w_prod_full;
  logic [DW-1:0]   w_prod_trunc;
  logic [RW-1:0]   w_sum_t;
  logic [FW-1:0]   w_sum_f;
  logic            w_last;
  logic            w_capture;

  assign w_capture = (r_state == IDLE) && en_in;
  assign w_last    = (r_idx == idx_t'(N_TERMS - 1));

  // Term idx uses the operand pair {2*idx, 2*idx+1}.
  assign w_a = r_op[{r_idx, 1'b0}];
  assign w_b = r_op[{r_idx, 1'b1}];

  q06_mul_trunc u_mul (
    .a          (w_a),
    .b          (w_b),
    .prod_full  (w_prod_full),
    .prod_trunc (w_prod_trunc)
  );

  assign w_sum_t = r_acc_t + RW'(w_prod_trunc);
  assign w_sum_f = r_acc_f + FW'(w_prod_full);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    en_out = 1'b0;
    unique case (r_state)
      IDLE: if (en_in) w_next = MAC;
      MAC: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        en_out = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand registers need no reset: they are only read after a capture.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_op[0] <= num1;
      r_op[1] <= num2;
      r_op[2] <= num3;
      r_op[3] <= num4;
      r_op[4] <= num5;
      r_op[5] <= num6;
      r_op[6] <= num7;
      r_op[7] <= num8;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx         <= '0;
      r_acc_t       <= '0;
      r_acc_f       <= '0;
      r_result      <= '0;
      r_result_full <= '0;
    end else if (w_capture) begin
      r_idx   <= '0;
      r_acc_t <= '0;
      r_acc_f <= '0;
    end else if (r_state == MAC) begin
      r_idx   <= r_idx + idx_t'(1);
      r_acc_t <= w_sum_t;
      r_acc_f <= w_sum_f;
      if (w_last) begin
        r_result      <= w_sum_t;
        r_result_full <= w_sum_f;
      end
    end
  end

  assign result      = r_result;
  assign result_full = r_result_full;

endmodule

// File: tb/tb_dot4_mac_seq.sv
// Directed plus randomized checks of dot4_mac_seq against an arithmetic model.
module tb_dot4_mac_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_in;
  logic [5:0]  num1, num2, num3, num4, num5, num6, num7, num8;
  logic        busy;
  logic        en_out;
  logic [8:0]  result;
  logic [13:0] result_full;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int ops [8];

  dot4_mac_seq dut (
    .clk         (clk),
    .rst         (rst),
    .en_in       (en_in),
    .num1        (num1),
    .num2        (num2),
    .num3        (num3),
    .num4        (num4),
    .num5        (num5),
    .num6        (num6),
    .num7        (num7),
    .num8        (num8),
    .busy        (busy),
    .en_out      (en_out),
    .result      (result),
    .result_full (result_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (en_out === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_ops();
    num1 = 6'(ops[0]); num2 = 6'(ops[1]); num3 = 6'(ops[2]); num4 = 6'(ops[3]);
    num5 = 6'(ops[4]); num6 = 6'(ops[5]); num7 = 6'(ops[6]); num8 = 6'(ops[7]);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 8; i++) ops[i] = v;
  endtask

  function automatic int model_trunc();
    int s = 0;
    for (int k = 0; k < 4; k++) s += (ops[2*k] * ops[2*k+1]) / 64;
    return s;
  endfunction

  function automatic int model_full();
    int s = 0;
    for (int k = 0; k < 4; k++) s += ops[2*k] * ops[2*k+1];
    return s;
  endfunction

  task automatic wait_en_out(output int lat);
    lat = 0;
    while (en_out !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // One full transaction from IDLE with en_in dropped right after capture.
  task automatic do_op(input string tag);
    int lat;
    int exp_t;
    int exp_f;
    exp_t = model_trunc();
    exp_f = model_full();
    apply_ops();
    en_in = 1'b1;
    step();
    en_in = 1'b0;
    check({tag, "_busy_cap"}, 32'(busy), 32'd1);
    check({tag, "_enout_cap"}, 32'(en_out), 32'd0);
    wait_en_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_enout"}, 32'(en_out), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp_t));
    check({tag, "_result_full"}, 32'(result_full), 32'(exp_f));
    step();
    check({tag, "_enout_clr"}, 32'(en_out), 32'd0);
    check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    check({tag, "_result_hold"}, 32'(result), 32'(exp_t));
  endtask

  initial begin
    int lat;
    int p0;

    rst   = 1'b0;
    en_in = 1'b0;
    fill(0);
    apply_ops();
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enout", 32'(en_out), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_result_full", 32'(result_full), 32'd0);
    rst = 1'b1;
    step();

    fill(32); do_op("half");
    fill(63); do_op("max");
    fill(0);  do_op("zero");
    fill(0); ops[0] = 1; ops[1] = 63; do_op("trunc_1x63");
    fill(0); ops[0] = 8; ops[1] = 8; ops[2] = 8; ops[3] = 8; do_op("eights");

    // Operands and en_in changes while busy must be ignored.
    fill(32); apply_ops();
    en_in = 1'b1;
    step();
    p0 = pulses;
    fill(63); apply_ops();
    en_in = 1'b0;
    step();
    en_in = 1'b1;
    step();
    en_in = 1'b0;
    wait_en_out(lat);
    check("ign_enout", 32'(en_out), 32'd1);
    check("ign_result", 32'(result), 32'd64);
    check("ign_result_full", 32'(result_full), 32'd4096);
    repeat (4) step();
    check("ign_pulses", 32'(pulses - p0), 32'd1);

    // Reset in the middle of MAC aborts the operation.
    fill(32); apply_ops();
    en_in = 1'b1;
    step();
    en_in = 1'b0;
    step();
    rst = 1'b0;
    p0 = pulses;
    step();
    rst = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_enout", 32'(en_out), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_result_full", 32'(result_full), 32'd0);
    repeat (8) step();
    check("abort_pulses", 32'(pulses - p0), 32'd0);
    fill(32); do_op("post_abort");

    // en_in held high: completions every 6 cycles.
    fill(32); apply_ops();
    en_in = 1'b1;
    wait_en_out(lat);
    check("b2b_first", 32'(en_out), 32'd1);
    step();
    lat = 1;
    while (en_out !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check("b2b_interval", 32'(lat), 32'd6);
    en_in = 1'b0;
    repeat (3) step();

    // Requester loop: drop en_in on en_out, reassert one cycle later.
    p0 = pulses;
    for (int i = 0; i < 8; i++) ops[i] = int'($urandom_range(63));
    apply_ops();
    en_in = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      wait_en_out(lat);
      check("rnd_latency", 32'(lat), 32'd5);
      check("rnd_result", 32'(result), 32'(model_trunc()));
      check("rnd_result_full", 32'(result_full), 32'(model_full()));
      en_in = 1'b0;
      step();
      if (v < 999) begin
        for (int i = 0; i < 8; i++) ops[i] = int'($urandom_range(63));
        apply_ops();
        en_in = 1'b1;
      end
    end
    repeat (4) step();
    check("rnd_pulses", 32'(pulses - p0), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot4_mac_seq.md
Name: dot4_mac_seq

Overview:
- Responder side of the en_in/en_out operand handshake.
- Accepts eight unsigned Q0.6 operands (value/64) and computes the 4-term dot product a1*b1 + a2*b2 + a3*b3 + a4*b4.
- Time-multiplexes one 6x6 multiplier over four cycles.
- Returns two results:
  - per-term-truncated Q sum, for compatibility with the bench golden model;
  - full-precision sum, for MAE studies.

Parameters:
- DW, 6, operand width (unsigned).
- FRAC, 6, fractional bits; each per-term product is shifted right by FRAC (truncation, no rounding).
- N_TERMS, 4, number of product terms. Fixed at 4 in this revision; other values are not required.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low.
- en_in  in  1  operands valid (level). Sampled only in IDLE.
- num1..num8  in  6 each  operands; pairs are (num1,num2), (num3,num4), (num5,num6), (num7,num8).
- busy  out  1  high from the capture edge until the DONE cycle ends.
- en_out  out  1  one-cycle pulse: results are valid/updated.
- result  out  9  sum of four ((a*b)>>6) terms; max 4*62 = 248.
- result_full  out  14  sum of four full products a*b; max 4*3969 = 15876.

Behaviour:
- Reset (rst low at a rising edge):
  - state=IDLE, term index=0, accumulators=0;
  - en_out=0, busy=0, result=0, result_full=0.
  - Reset has priority over all other activity.
- States:
  - IDLE: on an edge with en_in=1, register all eight operands, clear both accumulators, set idx=0, set busy=1, go to MAC. With en_in=0, stay in IDLE.
  - MAC: each edge computes p = op[2*idx] * op[2*idx+1] (12 bits), acc_t += p>>6, acc_f += p, idx++.
    - On the edge where idx==3, load result/result_full with the final sums (acc + this term), set en_out=1, go to DONE.
  - DONE: one cycle only. Next edge: en_out=0, busy=0, go to IDLE.
    - en_in is not sampled in DONE, so no capture occurs on the edge that leaves DONE.
- Latency, with capture edge C:
  - accumulation on edges C+1..C+4;
  - en_out high during cycle (C+4, C+5];
  - earliest next capture at edge C+6.
- Handshake rules:
  - en_in is ignored while busy=1. Operand changes after capture do not affect the result.
  - A requester that drops en_in on seeing en_out and reasserts one cycle later is served without loss.
  - en_in held permanently high gives back-to-back operation every 6 cycles.
- Output holding: result and result_full hold their last values between completions. They change only on the edge that raises en_out.
- Width rules:
  - products zero-extended to 12 bits;
  - truncated term is 6 bits;
  - accumulators are 9 and 14 bits;
  - no overflow is possible at the default parameters; no saturation logic.
- Reset mid-operation (rst low in MAC or DONE): abort immediately. No en_out pulse for the aborted operation; outputs return to 0.
- Boundary values:
  - zero operands give result=0;
  - 63*63 gives a term of 62;
  - 1*63 gives a term of 0 (truncation is per term, before summation).

Decomposition:
- Package dot4_pkg:
  - constants DW=6, FRAC=6, N_TERMS=4, RW=9, FW=14;
  - state enum {IDLE, MAC, DONE};
  - 2-bit term-index type.
- Sub-module q06_mul_trunc (combinational):
  - inputs a, b;
  - outputs prod_full[11:0] and prod_trunc[5:0] = prod_full>>6.
- The top contains the FSM, operand registers, operand mux and accumulators.

Test Plan:
- All operands 32 (0.5), en_in=1 at C -> en_out pulse in cycle after C+4, result=64, result_full=4096, busy high C..C+5.
- All operands 63 -> result=248, result_full=15876; all operands 0 -> result=0, result_full=0.
- num1=1, num2=63, rest 0 -> result=0, result_full=63; num1=num2=8 plus num3=num4=8 -> result=2, result_full=128.
- Capture 32s, then at C+1 drive all operands 63 and toggle en_in -> result=64 (ignored while busy), exactly one en_out pulse.
- rst low at edge C+2 -> no en_out, result=0, busy=0. Next capture of 32s -> result=64 normally.
- Requester-style loop (drop en_in on en_out, new {$random}%64 operands, reassert next cycle), 1000 vectors:
  - result equals the sum of four (a*b/64) every time, so MAE=0;
  - result_full equals the exact sum;
  - exactly 1000 en_out pulses.
